// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus bundle between the pipeline (decode/writeback) and the multi-port
// register file. The clock and reset are not part of the bundle.
//
// Signals:
//   clr        clear request pulse, starts a clear sweep
//   we3/wa3/wd3  write port 3 (enable, address, data)
//   we4/wa4/wd4  write port 4 (enable, address, data)
//   ra         packed read addresses, port i at ra[i*AW +: AW]
//   rd         packed read data, port i at rd[i*WIDTH +: WIDTH]
//   busy       high while a clear sweep is in progress
//
// Modports: master (pipeline side) and slave (register file side).
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
) ();
  logic                   clr;
  logic                   we3;
  logic [AW-1:0]          wa3;
  logic [WIDTH-1:0]       wd3;
  logic                   we4;
  logic [AW-1:0]          wa4;
  logic [WIDTH-1:0]       wd4;
  logic [NREAD*AW-1:0]    ra;
  logic [NREAD*WIDTH-1:0] rd;
  logic                   busy;

  modport master (
    output clr, we3, wa3, wd3, we4, wa4, wd4, ra,
    input  rd, busy
  );

  modport slave (
    input  clr, we3, wa3, wd3, we4, wa4, wd4, ra,
    output rd, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file with two write ports, NREAD combinational read
// ports, an optional hardwired zero register and a counter-driven clear sweep.
// A sweep is started by reset or by a clr pulse and zeroes one entry per edge;
// while it runs (busy=1) writes are dropped and every read port returns 0.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset, starts a clear sweep
//   bus    regfile_mp_if slave modport (write ports, read ports, clr, busy)
//
// Optional feature macro: REGFILE_MP_BYPASS_EN
//   defined   - a read whose address matches an enabled, valid write in the
//               same cycle returns that write data (port 4 over port 3)
//   undefined - reads show the stored contents only
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // Widened by one bit so DEPTH itself is representable for the range check.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             sweep_wen;
  logic             wen3, wen4;
  logic [NREAD*WIDTH-1:0] rd_all;

  // An address is usable when it maps onto a real entry and is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes only land in IDLE on an edge that is not starting a new sweep.
  assign wen3 = bus.we3 && (state_q == IDLE) && !reset && !bus.clr && addr_ok(bus.wa3);
  assign wen4 = bus.we4 && (state_q == IDLE) && !reset && !bus.clr && addr_ok(bus.wa4);

  // Sweep FSM: clr (re)starts at index 0 without clearing on that edge;
  // otherwise each CLEAR edge zeroes mem[cnt] and the last index returns to IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    sweep_wen = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (bus.clr) begin
          cnt_d = '0;
        end else begin
          sweep_wen = !reset;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
    endcase
  end

  // Reset overrides everything and holds the counter at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset; the sweep is what initialises it. Port 4 is
  // written last so it wins an address collision with port 3.
  always_ff @(posedge clk) begin
    if (sweep_wen) mem_q[cnt_q]   <= '0;
    if (wen3)      mem_q[bus.wa3] <= bus.wd3;
    if (wen4)      mem_q[bus.wa4] <= bus.wd4;
  end

  // Read ports: zero while busy or for unusable addresses.
  always_comb begin
    rd_all = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (!busy_q && addr_ok(bus.ra[i*AW +: AW])) begin
        rd_all[i*WIDTH +: WIDTH] = mem_q[bus.ra[i*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        if (wen3 && (bus.wa3 == bus.ra[i*AW +: AW])) rd_all[i*WIDTH +: WIDTH] = bus.wd3;
        if (wen4 && (bus.wa4 == bus.ra[i*AW +: AW])) rd_all[i*WIDTH +: WIDTH] = bus.wd4;
`else
        rd_all[i*WIDTH +: WIDTH] = mem_q[bus.ra[i*AW +: AW]];
`endif
      end
    end
  end

  assign bus.rd   = rd_all;
  assign bus.busy = busy_q;

endmodule
